pcs_receive: RTL and testbench

PCS receive state machine for the 1000BASE-X PCS data path, the receive-side counterpart of the PCS transmit ordered-set generator. It consumes byte-wide, already decoded and aligned code-groups from the synchronization/decoder stage. It strips idle and framing ordered sets and presents a GMII-style receive interface (RXD/RX_DV/RX_ER) to the MAC side, with per-frame good/bad counters.

---
 rtl/pcs_receive_if.sv | 29 ++
 rtl/pcs_receive.sv | 143 ++++++++++++++
 tb/tb_pcs_receive.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pcs_receive_if.sv
// Receive-side bundle between the code-group decoder and the MAC-facing PCS receive logic.
//   master: decoder side; drives sync_status, rx_code, rx_is_k and rx_code_err, and observes
//           the GMII-style outputs and the frame counters.
//   slave : pcs_receive; consumes the code-groups and drives rxd, rx_dv, rx_er, receiving,
//           good_frames and bad_frames.
interface pcs_receive_if #(
  parameter int unsigned CNT_W = 16
);
  logic             sync_status;
  logic [7:0]       rx_code;
  logic             rx_is_k;
  logic             rx_code_err;
  logic [7:0]       rxd;
  logic             rx_dv;
  logic             rx_er;
  logic             receiving;
  logic [CNT_W-1:0] good_frames;
  logic [CNT_W-1:0] bad_frames;

  modport master (
    output sync_status, rx_code, rx_is_k, rx_code_err,
    input  rxd, rx_dv, rx_er, receiving, good_frames, bad_frames
  );

  modport slave (
    input  sync_status, rx_code, rx_is_k, rx_code_err,
    output rxd, rx_dv, rx_er, receiving, good_frames, bad_frames
  );
endinterface

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive state machine.
// Strips idle and framing ordered sets from decoded, aligned code-groups and presents a
// GMII-style receive stream (rxd/rx_dv/rx_er) with good/bad frame counters.
// Ports:
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : pcs_receive_if.slave
//           in : sync_status, rx_code[7:0], rx_is_k, rx_code_err
//           out: rxd[7:0], rx_dv, rx_er, receiving, good_frames, bad_frames (CNT_W wide)
// All outputs are registered; the response to a code-group appears one cycle later.
module pcs_receive #(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  pcs_receive_if.slave bus
);

  localparam logic [7:0] KComma = 8'hBC;  // K28.5
  localparam logic [7:0] KStart = 8'hFB;  // K27.7 /S/
  localparam logic [7:0] KTerm  = 8'hFD;  // K29.7 /T/
  localparam logic [7:0] KCarry = 8'hF7;  // K23.7 /R/
  localparam logic [7:0] DPre   = 8'h55;  // preamble byte replacing /S/

  typedef enum logic [5:0] {
    StWaitSync = 6'b000001,
    StIdleK    = 6'b000010,
    StIdleD    = 6'b000100,
    StReceive  = 6'b001000,
    StEndR     = 6'b010000,
    StExtend   = 6'b100000
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       rxd_q, rxd_d;
  logic             rx_dv_q, rx_dv_d;
  logic             rx_er_q, rx_er_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  logic is_comma, is_start, is_term, is_carry;

  assign is_comma = bus.rx_is_k && (bus.rx_code == KComma);
  assign is_start = bus.rx_is_k && (bus.rx_code == KStart);
  assign is_term  = bus.rx_is_k && (bus.rx_code == KTerm);
  assign is_carry = bus.rx_is_k && (bus.rx_code == KCarry);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StWaitSync;
      rxd_q      <= 8'h00;
      rx_dv_q    <= 1'b0;
      rx_er_q    <= 1'b0;
      err_flag_q <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      rxd_q      <= rxd_d;
      rx_dv_q    <= rx_dv_d;
      rx_er_q    <= rx_er_d;
      err_flag_q <= err_flag_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rxd_d      = 8'h00;
    rx_dv_d    = 1'b0;
    rx_er_d    = 1'b0;
    err_flag_d = err_flag_q;
    good_d     = good_q;
    bad_d      = bad_q;

    if (!bus.sync_status) begin
      // Loss of lock overrides everything; a frame in flight is lost.
      state_d = StWaitSync;
      if (state_q == StReceive) begin
        bad_d = bad_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        StWaitSync: state_d = StIdleK;
        StIdleK: begin
          if (is_comma) begin
            state_d = StIdleD;
          end else if (is_start) begin
            state_d    = StReceive;
            rxd_d      = DPre;
            rx_dv_d    = 1'b1;
            err_flag_d = 1'b0;
          end
        end
        StIdleD: state_d = StIdleK;
        StReceive: begin
          // A code error wins over any decoded meaning of the byte.
          if (!bus.rx_code_err && !bus.rx_is_k) begin
            rxd_d   = bus.rx_code;
            rx_dv_d = 1'b1;
          end else if (!bus.rx_code_err && is_term) begin
            state_d = StEndR;
            if (err_flag_q) begin
              bad_d = bad_q + 1'b1;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else if (!bus.rx_code_err && is_comma) begin
            state_d = StIdleD;
            rx_er_d = 1'b1;
            bad_d   = bad_q + 1'b1;
          end else begin
            rxd_d      = bus.rx_code;
            rx_dv_d    = 1'b1;
            rx_er_d    = 1'b1;
            err_flag_d = 1'b1;
          end
        end
        StEndR: state_d = is_carry ? StExtend : StIdleK;
        StExtend: begin
          if (is_carry) begin
            state_d = StExtend;
          end else if (is_comma) begin
            state_d = StIdleD;
          end else begin
            state_d = StIdleK;
          end
        end
        default: state_d = StWaitSync;
      endcase
    end
  end

  assign bus.rxd         = rxd_q;
  assign bus.rx_dv       = rx_dv_q;
  assign bus.rx_er       = rx_er_q;
  assign bus.receiving   = (state_q == StReceive) || (state_q == StEndR) || (state_q == StExtend);
  assign bus.good_frames = good_q;
  assign bus.bad_frames  = bad_q;

endmodule

// File: tb/tb_pcs_receive.sv
module tb_pcs_receive;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pcs_receive_if #(.CNT_W(16)) bus  ();
  pcs_receive_if #(.CNT_W(2))  bus2 ();

  pcs_receive #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy fed the same stimulus, for the wrap check.
  pcs_receive #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sync(input logic s);
    bus.sync_status  = s;
    bus2.sync_status = s;
  endtask

  // Present one code-group, clock it, and settle just after the edge.
  task automatic step(input logic [7:0] code, input logic k, input logic err);
    bus.rx_code      = code;
    bus.rx_is_k      = k;
    bus.rx_code_err  = err;
    bus2.rx_code     = code;
    bus2.rx_is_k     = k;
    bus2.rx_code_err = err;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic dv, input logic er);
    chk({tag, ".rxd"}, {24'd0, bus.rxd}, {24'd0, d});
    chk({tag, ".dv"}, {31'd0, bus.rx_dv}, {31'd0, dv});
    chk({tag, ".er"}, {31'd0, bus.rx_er}, {31'd0, er});
  endtask

  // From IDLE_K: /S/ 11 22 33 /T/ /R/ K28.5 D5.6, back in IDLE_K.
  task automatic clean_frame(input string tag);
    step(8'hFB, 1'b1, 1'b0); chk_out({tag, ".pre"}, 8'h55, 1'b1, 1'b0);
    step(8'h11, 1'b0, 1'b0); chk_out({tag, ".d0"}, 8'h11, 1'b1, 1'b0);
    step(8'h22, 1'b0, 1'b0); chk_out({tag, ".d1"}, 8'h22, 1'b1, 1'b0);
    step(8'h33, 1'b0, 1'b0); chk_out({tag, ".d2"}, 8'h33, 1'b1, 1'b0);
    step(8'hFD, 1'b1, 1'b0); chk_out({tag, ".t"}, 8'h00, 1'b0, 1'b0);
    step(8'hF7, 1'b1, 1'b0);
    step(8'hBC, 1'b1, 1'b0);
    step(8'hC5, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    set_sync(1'b0);
    bus.rx_code  = 8'h00; bus.rx_is_k  = 1'b0; bus.rx_code_err  = 1'b0;
    bus2.rx_code = 8'h00; bus2.rx_is_k = 1'b0; bus2.rx_code_err = 1'b0;

    // Reset for 3 cycles, then release with no lock.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    chk_out("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.recv", {31'd0, bus.receiving}, 32'd0);
    chk("rst.good", {16'd0, bus.good_frames}, 32'd0);
    chk("rst.bad", {16'd0, bus.bad_frames}, 32'd0);

    // Acquire sync, idles only.
    set_sync(1'b1);
    step(8'hBC, 1'b1, 1'b0);
    step(8'hBC, 1'b1, 1'b0); chk_out("idle0", 8'h00, 1'b0, 1'b0);
    step(8'hC5, 1'b0, 1'b0); chk_out("idle1", 8'h00, 1'b0, 1'b0);

    // Clean frame.
    clean_frame("clean");
    chk("clean.good", {16'd0, bus.good_frames}, 32'd1);
    chk("clean.bad", {16'd0, bus.bad_frames}, 32'd0);
    chk("clean.recv", {31'd0, bus.receiving}, 32'd0);

    // Code error on the 0x22 byte.
    step(8'hFB, 1'b1, 1'b0); chk_out("err.pre", 8'h55, 1'b1, 1'b0);
    chk("err.recv", {31'd0, bus.receiving}, 32'd1);
    step(8'h11, 1'b0, 1'b0); chk_out("err.d0", 8'h11, 1'b1, 1'b0);
    step(8'h22, 1'b0, 1'b1); chk_out("err.d1", 8'h22, 1'b1, 1'b1);
    step(8'h33, 1'b0, 1'b0); chk_out("err.d2", 8'h33, 1'b1, 1'b0);
    step(8'hFD, 1'b1, 1'b0); chk_out("err.t", 8'h00, 1'b0, 1'b0);
    chk("err.good", {16'd0, bus.good_frames}, 32'd1);
    chk("err.bad", {16'd0, bus.bad_frames}, 32'd1);
    step(8'hF7, 1'b1, 1'b0);
    chk("err.ext", {31'd0, bus.receiving}, 32'd1);
    step(8'hBC, 1'b1, 1'b0);
    step(8'hC5, 1'b0, 1'b0);

    // Back-to-back with shortest gap: /T/ /R/ /S/ /S/.
    step(8'hFB, 1'b1, 1'b0); chk_out("b2b.pre", 8'h55, 1'b1, 1'b0);
    step(8'hAB, 1'b0, 1'b0); chk_out("b2b.d0", 8'hAB, 1'b1, 1'b0);
    step(8'hFD, 1'b1, 1'b0);
    chk("b2b.good", {16'd0, bus.good_frames}, 32'd2);
    step(8'hF7, 1'b1, 1'b0);
    step(8'hFB, 1'b1, 1'b0); chk_out("b2b.gap", 8'h00, 1'b0, 1'b0);
    chk("b2b.gaprecv", {31'd0, bus.receiving}, 32'd0);
    step(8'hFB, 1'b1, 1'b0); chk_out("b2b.pre2", 8'h55, 1'b1, 1'b0);
    step(8'h01, 1'b0, 1'b0); chk_out("b2b.d1", 8'h01, 1'b1, 1'b0);
    step(8'hFD, 1'b1, 1'b0);
    chk("b2b.good2", {16'd0, bus.good_frames}, 32'd3);
    chk("b2b.bad2", {16'd0, bus.bad_frames}, 32'd1);
    step(8'hBC, 1'b1, 1'b0);  // END_R -> IDLE_K

    // Early comma.
    step(8'hFB, 1'b1, 1'b0); chk_out("ec.pre", 8'h55, 1'b1, 1'b0);
    step(8'hAA, 1'b0, 1'b0); chk_out("ec.d0", 8'hAA, 1'b1, 1'b0);
    step(8'hBC, 1'b1, 1'b0); chk_out("ec.end", 8'h00, 1'b0, 1'b1);
    chk("ec.bad", {16'd0, bus.bad_frames}, 32'd2);
    chk("ec.recv", {31'd0, bus.receiving}, 32'd0);
    step(8'hC5, 1'b0, 1'b0); chk_out("ec.after", 8'h00, 1'b0, 1'b0);

    // Sync loss mid-frame.
    step(8'hFB, 1'b1, 1'b0);
    step(8'h11, 1'b0, 1'b0); chk_out("sl.d0", 8'h11, 1'b1, 1'b0);
    set_sync(1'b0);
    step(8'h22, 1'b0, 1'b0); chk_out("sl.lost", 8'h00, 1'b0, 1'b0);
    chk("sl.bad", {16'd0, bus.bad_frames}, 32'd3);
    chk("sl.recv", {31'd0, bus.receiving}, 32'd0);
    set_sync(1'b1);
    step(8'hBC, 1'b1, 1'b0); chk_out("sl.re0", 8'h00, 1'b0, 1'b0);
    step(8'h33, 1'b0, 1'b0); chk_out("sl.re1", 8'h00, 1'b0, 1'b0);
    step(8'hFD, 1'b1, 1'b0); chk_out("sl.re2", 8'h00, 1'b0, 1'b0);
    chk("sl.good", {16'd0, bus.good_frames}, 32'd3);
    chk("sl.bad2", {16'd0, bus.bad_frames}, 32'd3);

    // Reset mid-frame clears everything with no count.
    step(8'hFB, 1'b1, 1'b0);
    step(8'h11, 1'b0, 1'b0); chk_out("mr.d0", 8'h11, 1'b1, 1'b0);
    reset = 1'b0;
    step(8'h22, 1'b0, 1'b0); chk_out("mr.rst", 8'h00, 1'b0, 1'b0);
    chk("mr.good", {16'd0, bus.good_frames}, 32'd0);
    chk("mr.bad", {16'd0, bus.bad_frames}, 32'd0);
    chk("mr.recv", {31'd0, bus.receiving}, 32'd0);
    reset = 1'b1;
    step(8'hBC, 1'b1, 1'b0);  // WAIT_SYNC -> IDLE_K

    // Five clean frames: 16-bit counter reads 5, 2-bit counter wraps to 1.
    for (int i = 0; i < 5; i++) begin
      clean_frame($sformatf("wrap%0d", i));
    end
    chk("wrap.good16", {16'd0, bus.good_frames}, 32'd5);
    chk("wrap.good2", {30'd0, bus2.good_frames}, 32'd1);
    chk("wrap.bad2", {30'd0, bus2.bad_frames}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
